// File: rtl/regfile_mp.sv
// Multi-port integer register file with prioritised write arbitration,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned s_width = 32,
  parameter int unsigned s_index = 5,
  parameter int unsigned n_write = 2,
  parameter int unsigned n_read  = 2,
  parameter bit          bypass  = 1'b1,
  localparam int unsigned PW     = (n_write > 1) ? $clog2(n_write) : 1,
  localparam int unsigned NREGS  = 2 ** s_index
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PW-1:0]                     prefer,
  input  logic [n_write-1:0]                wr_en,
  input  logic [n_write-1:0][s_index-1:0]   wr_idx,
  input  logic [n_write-1:0][s_width-1:0]   wr_data,
  input  logic [n_write-1:0]                wr_clr,
  input  logic                              rsv_en,
  input  logic [s_index-1:0]                rsv_idx,
  input  logic [n_read-1:0][s_index-1:0]    rd_idx,
  output logic [n_read-1:0][s_width-1:0]    rd_data,
  output logic [n_read-1:0]                 rd_busy,
  output logic [s_index:0]                  num_busy
);

  logic [s_width-1:0] mem [NREGS];
  logic [NREGS-1:0]   busy;
  logic [NREGS-1:0]   busy_next;
  logic [NREGS-1:0]   wr_hit;
  logic [NREGS-1:0]   clr_hit;
  logic [NREGS-1:0]   rsv_hit;
  logic [s_width-1:0] wr_val [NREGS];
  logic [n_write-1:0] win;
  logic               pref_valid;
  logic [s_index:0]   cnt;

  assign pref_valid = (32'(prefer) < n_write);

  // A port loses to the preferred port on a shared destination, otherwise
  // to any lower-numbered port on that destination.
  always_comb begin
    win = '0;
    for (int unsigned p = 0; p < n_write; p++) begin
      win[p] = !rst && wr_en[p] && (wr_idx[p] != '0);
      for (int unsigned q = 0; q < n_write; q++) begin
        if (q != p && wr_en[q] && wr_idx[q] == wr_idx[p]) begin
          if (pref_valid && q == 32'(prefer))
            win[p] = 1'b0;
          else if (q < p && !(pref_valid && p == 32'(prefer)))
            win[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    rsv_hit = '0;
    for (int unsigned r = 0; r < NREGS; r++) wr_val[r] = '0;
    for (int unsigned p = 0; p < n_write; p++) begin
      if (win[p]) begin
        wr_hit[wr_idx[p]] = 1'b1;
        wr_val[wr_idx[p]] = wr_data[p];
        if (wr_clr[p]) clr_hit[wr_idx[p]] = 1'b1;
      end
    end
    if (!rst && rsv_en && rsv_idx != '0) rsv_hit[rsv_idx] = 1'b1;
  end

  // Reserve overrides a same-cycle clear: it names a new producer.
  always_comb begin
    busy_next = (busy & ~clr_hit) | rsv_hit;
    cnt = '0;
    for (int unsigned r = 0; r < NREGS; r++)
      cnt = cnt + {{s_index{1'b0}}, busy_next[r]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
      busy     <= '0;
      num_busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++)
        if (wr_hit[r]) mem[r] <= wr_val[r];
      busy     <= busy_next;
      num_busy <= cnt;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < n_read; i++) begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (!rst && rd_idx[i] != '0) begin
        rd_data[i] = (bypass && wr_hit[rd_idx[i]]) ? wr_val[rd_idx[i]] : mem[rd_idx[i]];
        rd_busy[i] = (bypass && clr_hit[rd_idx[i]]) ? rsv_hit[rd_idx[i]] : busy[rd_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share all inputs.
module tb_regfile_mp;
  logic                 clk = 1'b0;
  logic                 rst;
  logic [0:0]           prefer;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_idx;
  logic [1:0][31:0]     wr_data;
  logic [1:0]           wr_clr;
  logic                 rsv_en;
  logic [4:0]           rsv_idx;
  logic [1:0][4:0]      rd_idx;
  logic [1:0][31:0]     rd_data_b, rd_data_n;
  logic [1:0]           rd_busy_b, rd_busy_n;
  logic [5:0]           num_busy_b, num_busy_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.s_width(32), .s_index(5), .n_write(2), .n_read(2), .bypass(1'b1)) u_dut (
    .clk(clk), .rst(rst), .prefer(prefer), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_clr(wr_clr), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
    .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b), .num_busy(num_busy_b));

  regfile_mp #(.s_width(32), .s_index(5), .n_write(2), .n_read(2), .bypass(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .prefer(prefer), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_clr(wr_clr), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
    .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n), .num_busy(num_busy_n));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_clr = '0; rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] idx, input logic [31:0] d, input logic clr);
    wr_en[p] = 1'b1; wr_idx[p] = idx; wr_data[p] = d; wr_clr[p] = clr;
  endtask

  task automatic rsv(input logic [4:0] idx);
    rsv_en = 1'b1; rsv_idx = idx;
  endtask

  initial begin
    rst = 1'b1; prefer = '0; idle(); wr_idx = '0; wr_data = '0; rsv_idx = '0; rd_idx = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    for (int i = 0; i < 32; i++) begin
      rd_idx[0] = 5'(i); rd_idx[1] = 5'(31 - i);
      #1;
      check($sformatf("rst_data_%0d", i), {rd_data_b[0], rd_data_b[1]}, 64'h0);
      check($sformatf("rst_busy_%0d", i), {62'h0, rd_busy_b}, 64'h0);
    end
    check("rst_num_busy", 64'(num_busy_b), 64'h0);

    wr(0, 5'd0, 32'hFFFF_FFFF, 1'b0); rd_idx[0] = 5'd0;
    #1 check("r0_bypass", 64'(rd_data_b[0]), 64'h0);
    tick(); idle();
    check("r0_after", 64'(rd_data_b[0]), 64'h0);
    check("r0_after_nb", 64'(rd_data_n[0]), 64'h0);

    prefer = 1'b1; wr(0, 5'd5, 32'h11, 1'b0); wr(1, 5'd5, 32'h22, 1'b0);
    tick(); idle(); rd_idx[0] = 5'd5;
    #1 check("pref1_r5", 64'(rd_data_n[0]), 64'h22);
    prefer = 1'b0; wr(0, 5'd5, 32'h11, 1'b0); wr(1, 5'd5, 32'h22, 1'b0);
    tick(); idle();
    #1 check("pref0_r5", 64'(rd_data_n[0]), 64'h11);

    wr(0, 5'd6, 32'hA, 1'b0); wr(1, 5'd7, 32'hB, 1'b0);
    tick(); idle(); rd_idx[0] = 5'd6; rd_idx[1] = 5'd7;
    #1 check("dual_r6", 64'(rd_data_n[0]), 64'hA);
    check("dual_r7", 64'(rd_data_n[1]), 64'hB);

    wr(0, 5'd9, 32'hDEAD_BEEF, 1'b0); rd_idx[0] = 5'd9;
    #1 check("byp_same", 64'(rd_data_b[0]), 64'hDEAD_BEEF);
    check("nobyp_same", 64'(rd_data_n[0]), 64'h0);
    tick(); idle();
    #1 check("nobyp_next", 64'(rd_data_n[0]), 64'hDEAD_BEEF);

    rsv(5'd3); tick(); idle();
    check("nb_after_r3", 64'(num_busy_b), 64'd1);
    rsv(5'd4); tick(); idle();
    check("nb_after_r4", 64'(num_busy_b), 64'd2);
    rsv(5'd5); tick(); idle();
    check("nb_after_r5", 64'(num_busy_n), 64'd3);
    rd_idx[0] = 5'd3;
    #1 check("busy_r3", 64'(rd_busy_b[0]), 64'h1);

    wr(1, 5'd4, 32'h44, 1'b1); rd_idx[0] = 5'd4;
    #1 check("clr_byp_same", 64'(rd_busy_b[0]), 64'h0);
    check("clr_nobyp_same", 64'(rd_busy_n[0]), 64'h1);
    tick(); idle();
    check("nb_after_clr", 64'(num_busy_b), 64'd2);
    check("busy_r4_clr", 64'(rd_busy_n[0]), 64'h0);

    rsv(5'd0); tick(); idle(); rd_idx[0] = 5'd0;
    #1 check("nb_rsv_r0", 64'(num_busy_b), 64'd2);
    check("busy_r0", 64'(rd_busy_n[0]), 64'h0);

    prefer = 1'b0; wr(0, 5'd5, 32'h50, 1'b0); wr(1, 5'd5, 32'h51, 1'b1);
    tick(); idle(); rd_idx[0] = 5'd5;
    #1 check("loser_clr_busy", 64'(rd_busy_n[0]), 64'h1);
    check("loser_clr_data", 64'(rd_data_n[0]), 64'h50);
    check("loser_clr_nb", 64'(num_busy_b), 64'd2);

    rsv(5'd8); wr(0, 5'd8, 32'h88, 1'b1);
    tick(); idle(); rd_idx[0] = 5'd8;
    #1 check("rsvclr_busy", 64'(rd_busy_n[0]), 64'h1);
    check("rsvclr_data", 64'(rd_data_n[0]), 64'h88);
    check("rsvclr_nb", 64'(num_busy_b), 64'd3);

    rsv(5'd3); tick(); idle();
    check("rsv_again_nb", 64'(num_busy_b), 64'd3);

    rsv(5'd10); wr(0, 5'd10, 32'h55, 1'b0);
    tick(); idle(); rd_idx[0] = 5'd10; rd_idx[1] = 5'd11;
    #1 check("r10_data", 64'(rd_data_n[0]), 64'h55);
    check("r10_nb", 64'(num_busy_b), 64'd4);
    wr(0, 5'd11, 32'h77, 1'b0);
    #1 rst = 1'b1;
    #1 check("arst_data", {rd_data_b[0], rd_data_b[1]}, 64'h0);
    check("arst_busy", {60'h0, rd_busy_b, rd_busy_n}, 64'h0);
    check("arst_nb", {num_busy_b, num_busy_n}, 64'h0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    check("lost_write_r11", 64'(rd_data_n[1]), 64'h0);
    check("post_rst_r10", 64'(rd_data_b[0]), 64'h0);
    check("post_rst_nb", 64'(num_busy_b), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
